// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive path (slot FSM states, counter sizing).
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package tdm_pkg;

    typedef enum logic {HUNT, LOCK} tdm_state_t;

    // Width of the slot counter for a frame of ch slots.
    function automatic int slot_w(input int ch);
        return $clog2(ch);
    endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Modulo-CHANNELS slot position counter with increment, load-to-1 and clear.
// Latency: count updates on the edge after a control strobe; is_last is combinational from the count.
// Backpressure: none; the counter holds whenever no strobe is asserted.
module tdm_slot_cnt
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inc,
    input  logic                          load1,
    input  logic                          clr,
    output logic [slot_w(CHANNELS)-1:0]   slot_cnt,
    output logic                          is_last
);

    localparam int SW = slot_w(CHANNELS);

    assign is_last = (slot_cnt == SW'(CHANNELS - 1));

    // Clear wins over load, load wins over increment; increment wraps after the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
        end else if (clr) begin
            slot_cnt <= '0;
        end else if (load1) begin
            slot_cnt <= SW'(1);
        end else if (inc) begin
            slot_cnt <= is_last ? '0 : slot_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM word-stream demultiplexer: aligns on fsync, collects CHANNELS slot words, publishes whole frames (optional frame counter: TDM_DEMUX_FRMCNT_EN).
// Latency: one edge from the last slot word to dout/frame_vld.
// Backpressure: none; din_vld=0 freezes all state, frame_vld and sync_err are pulses.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_vld,
    input  logic                      fsync,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      frame_vld,
    output logic                      locked,
    output logic                      sync_err
`ifdef TDM_DEMUX_FRMCNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam int SW = slot_w(CHANNELS);

    tdm_state_t       state;
    logic [SW-1:0]    slot_cnt;
    logic             is_last;
    logic             cnt_zero;
    logic             cnt_inc;
    logic             cnt_load1;
    logic             cnt_clr;
    logic             emit;

    // The last slot word goes straight into dout, so only CHANNELS-1 words need holding.
    logic [WIDTH-1:0] shadow [CHANNELS-1];

    assign cnt_zero  = (slot_cnt == '0);
    // Any qualified fsync word starts a frame, whether in HUNT, on time, or early.
    assign cnt_load1 = din_vld & fsync;
    assign cnt_inc   = din_vld & (state == LOCK) & ~fsync & ~cnt_zero;
    // Keeps the counter parked at slot 0 while hunting.
    assign cnt_clr   = din_vld & (state == HUNT) & ~fsync;
    // is_last implies a non-zero count because CHANNELS >= 2.
    assign emit      = din_vld & (state == LOCK) & ~fsync & is_last;
    assign locked    = (state == LOCK);

    tdm_slot_cnt #(
        .CHANNELS (CHANNELS)
    ) u_slot_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (cnt_inc),
        .load1    (cnt_load1),
        .clr      (cnt_clr),
        .slot_cnt (slot_cnt),
        .is_last  (is_last)
    );

    // Framing FSM: slot steering into shadow regs, frame publish and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            dout      <= '0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
            for (int k = 0; k < CHANNELS - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
            if (din_vld) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            shadow[0] <= din;
                            state     <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (fsync) begin
                            // Early sync drops the partial frame; dout is left untouched.
                            if (!cnt_zero) begin
                                sync_err <= 1'b1;
                            end
                            shadow[0] <= din;
                        end else if (cnt_zero) begin
                            // Slot 0 arrived without its sync flag: alignment lost.
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end else if (is_last) begin
                            for (int k = 0; k < CHANNELS - 1; k++) begin
                                dout[k*WIDTH +: WIDTH] <= shadow[k];
                            end
                            dout[(CHANNELS-1)*WIDTH +: WIDTH] <= din;
                            frame_vld <= 1'b1;
                        end else begin
                            shadow[slot_cnt] <= din;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef TDM_DEMUX_FRMCNT_EN
    // Saturating count of published frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (emit && frame_cnt != 16'hFFFF) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CHANNELS=4, WIDTH=8): vector table plus reset/counter sequences.
// Latency: expectations are sampled 1 time unit after each rising edge.
// Backpressure: din_vld gaps are part of the stimulus.
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld;
    logic        fsync;
    logic [31:0] dout;
    logic        frame_vld;
    logic        locked;
    logic        sync_err;
`ifdef TDM_DEMUX_FRMCNT_EN
    logic [15:0] frame_cnt;
`endif

    int errors = 0;
    int checks = 0;

    tdm_demux #(
        .CHANNELS (4),
        .WIDTH    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .fsync     (fsync),
        .dout      (dout),
        .frame_vld (frame_vld),
        .locked    (locked),
        .sync_err  (sync_err)
`ifdef TDM_DEMUX_FRMCNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        fs;
        logic [7:0]  d;
        logic        fv;
        logic        se;
        logic        lk;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one word, let one edge pass, sample just after it.
    task automatic step(input logic v, input logic f, input logic [7:0] d);
        din_vld = v;
        fsync   = f;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic f, input logic [7:0] d,
                       input logic fv, input logic se, input logic lk, input logic [31:0] o);
        tbl.push_back('{vld: v, fs: f, d: d, fv: fv, se: se, lk: lk, dout: o});
    endtask

    initial begin
        rst_n   = 1'b0;
        din_vld = 1'b0;
        fsync   = 1'b0;
        din     = 8'h00;

        // 1: clean frame
        add(1, 1, 8'h11, 0, 0, 1, 32'h0);
        add(1, 0, 8'h22, 0, 0, 1, 32'h0);
        add(1, 0, 8'h33, 0, 0, 1, 32'h0);
        add(1, 0, 8'h44, 1, 0, 1, 32'h44332211);
        // 2: back-to-back frame with a 3-cycle gap (gap carries fsync and junk data)
        add(1, 1, 8'h15, 0, 0, 1, 32'h44332211);
        add(1, 0, 8'h26, 0, 0, 1, 32'h44332211);
        add(0, 1, 8'hFF, 0, 0, 1, 32'h44332211);
        add(0, 1, 8'hFF, 0, 0, 1, 32'h44332211);
        add(0, 0, 8'hEE, 0, 0, 1, 32'h44332211);
        add(1, 0, 8'h37, 0, 0, 1, 32'h44332211);
        add(1, 0, 8'h48, 1, 0, 1, 32'h48372615);
        // 3: early sync at B1
        add(1, 1, 8'hA1, 0, 0, 1, 32'h48372615);
        add(1, 0, 8'hA2, 0, 0, 1, 32'h48372615);
        add(1, 1, 8'hB1, 0, 1, 1, 32'h48372615);
        add(1, 0, 8'hB2, 0, 0, 1, 32'h48372615);
        add(1, 0, 8'hB3, 0, 0, 1, 32'h48372615);
        add(1, 0, 8'hB4, 1, 0, 1, 32'hB4B3B2B1);
        // 4: missing sync, hunt ignores words (and an unqualified fsync), then relock
        add(1, 0, 8'h55, 0, 1, 0, 32'hB4B3B2B1);
        add(1, 0, 8'h56, 0, 0, 0, 32'hB4B3B2B1);
        add(0, 1, 8'h57, 0, 0, 0, 32'hB4B3B2B1);
        add(1, 0, 8'h58, 0, 0, 0, 32'hB4B3B2B1);
        add(1, 0, 8'h59, 0, 0, 0, 32'hB4B3B2B1);
        add(1, 1, 8'h61, 0, 0, 1, 32'hB4B3B2B1);
        add(1, 0, 8'h62, 0, 0, 1, 32'hB4B3B2B1);
        add(1, 0, 8'h63, 0, 0, 1, 32'hB4B3B2B1);
        add(1, 0, 8'h64, 1, 0, 1, 32'h64636261);

        // Reset state
        #3;
        chk("rst dout", dout, 32'h0);
        chk("rst frame_vld", {31'b0, frame_vld}, 32'h0);
        chk("rst locked", {31'b0, locked}, 32'h0);
        chk("rst sync_err", {31'b0, sync_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].fs, tbl[i].d);
            chk($sformatf("v%0d frame_vld", i), {31'b0, frame_vld}, {31'b0, tbl[i].fv});
            chk($sformatf("v%0d sync_err", i), {31'b0, sync_err}, {31'b0, tbl[i].se});
            chk($sformatf("v%0d locked", i), {31'b0, locked}, {31'b0, tbl[i].lk});
            chk($sformatf("v%0d dout", i), dout, tbl[i].dout);
        end

        // 5: asynchronous reset after two slots, checked before the next edge
        step(1, 1, 8'h71);
        step(1, 0, 8'h72);
        din_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst dout", dout, 32'h0);
        chk("arst locked", {31'b0, locked}, 32'h0);
        chk("arst frame_vld", {31'b0, frame_vld}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Remainder of the interrupted frame must not be taken
        step(1, 0, 8'h73);
        chk("post-rst locked", {31'b0, locked}, 32'h0);
        step(1, 0, 8'h74);
        chk("post-rst frame_vld", {31'b0, frame_vld}, 32'h0);
        step(1, 1, 8'h81);
        step(1, 0, 8'h82);
        step(1, 0, 8'h83);
        chk("fresh early frame_vld", {31'b0, frame_vld}, 32'h0);
        chk("fresh early dout", dout, 32'h0);
        step(1, 0, 8'h84);
        chk("fresh frame_vld", {31'b0, frame_vld}, 32'h1);
        chk("fresh dout", dout, 32'h84838281);

        // 6: two more good frames, then an errored one
        step(1, 1, 8'hC1); step(1, 0, 8'hC2); step(1, 0, 8'hC3); step(1, 0, 8'hC4);
        chk("c dout", dout, 32'hC4C3C2C1);
        step(1, 1, 8'hD1); step(1, 0, 8'hD2); step(1, 0, 8'hD3); step(1, 0, 8'hD4);
        chk("d frame_vld", {31'b0, frame_vld}, 32'h1);
        chk("d dout", dout, 32'hD4D3D2D1);
        step(1, 1, 8'hE1); step(1, 0, 8'hE2);
        step(1, 1, 8'hE3);
        chk("e sync_err", {31'b0, sync_err}, 32'h1);
        chk("e frame_vld", {31'b0, frame_vld}, 32'h0);
        chk("e dout", dout, 32'hD4D3D2D1);
`ifdef TDM_DEMUX_FRMCNT_EN
        chk("frame_cnt", {16'b0, frame_cnt}, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
